sumsq_accum: RTL and testbench
==============================

Name: sumsq_accum

Overview:
- Streaming sum-of-squares accumulator sitting directly upstream of the ALU square-root unit.
- Accepts a vector of signed elements, one per beat, and squares and accumulates each one.
- On the last element, presents the unsigned saturated sum (the sqrt unit's unsigned input) through a valid/ready output register.
- The sqrt unit's out then yields the L2 norm of the vector.

Parameters:
- dataLen, 16, width of signed input element (two's complement).
- outLen, 32, width of unsigned sum; equals sqrt inLen; must be >= 2*dataLen.
- cntLen, 16, width of element counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  element present on in_data.
- in_ready  output  1  block can accept an element.
- in_data  input  dataLen  signed element.
- in_last  input  1  marks final element of vector; qualified by in_valid.
- out_valid  output  1  out_data/out_sat/out_count hold a finished result.
- out_ready  input  1  downstream (sqrt stage) accepts result.
- out_data  output  outLen  unsigned sum of squares, saturated.
- out_sat  output  1  sticky: sum clipped at any point in the vector.
- out_count  output  cntLen  number of elements in the vector, saturating at all-ones.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-high.
  - Reset values: in_ready=0 during reset, 1 in the first cycle after release; out_valid=0; out_data=0; out_sat=0; out_count=0; internal acc=0, cnt=0, sat=0; state=IDLE.
- States: IDLE, ACCUM, HOLD.
  - in_ready = (state != HOLD), registered-state decode.
- Accept: a beat transfers when in_valid & in_ready.
  - Beats with in_valid low are gaps and leave state unchanged.
- Square: sq = in_data*in_data, signed multiply, taken as a 2*dataLen unsigned value.
  - Max is 2^(2*dataLen-2), for -2^(dataLen-1).
- Accumulate: next = acc + sq, computed outLen+1 bits wide.
  - If bit outLen is set, or sat is already set: acc <= all-ones and sat <= 1.
  - Otherwise acc <= next[outLen-1:0].
  - cnt <= cnt+1, holding at all-ones.
  - sat is sticky within a vector.
- Transitions:
  - IDLE: accepted beat without last -> ACCUM, with acc=sq, cnt=1. Accepted beat with last -> HOLD.
  - ACCUM: accepted beat with last -> HOLD. Accepted beat without last -> stay in ACCUM.
  - HOLD: out_valid & out_ready -> IDLE, clearing acc/cnt/sat to 0.
- Result latching: on the last beat, out_data/out_sat/out_count load the value including that beat in the same edge.
  - out_valid rises the cycle after the last beat is accepted; latency is 1 cycle.
- HOLD and handshake:
  - out_data, out_sat and out_count are stable while out_valid=1 and out_ready=0.
  - in_ready=0 throughout HOLD, including the handshake cycle.
  - in_ready returns to 1 the cycle after the handshake.
  - in_valid during HOLD is ignored; the source must keep holding it.
- out_valid deasserts the cycle after the handshake.
  - out_data retains its last value; downstream must not sample it when out_valid=0.
- Single-element vector: IDLE -> HOLD directly.
- Empty vector: no valid beats means no result is produced.
- Simultaneous out handshake and in_valid: the element is not accepted that cycle.
- Reset mid-vector or mid-HOLD: partial sum discarded, out_valid drops immediately, and the next vector starts from 0.
- Counter: saturates, no wrap; out_count is informational only.

Test Plan:
- Vector [3,4], last on 4, out_ready=1 -> out_valid one cycle after 2nd beat; out_data=25, out_count=2, out_sat=0.
- Single beat [-32768], last -> out_data=0x40000000, out_count=1, out_sat=0.
- Three beats of -32768 -> 0xC0000000, sat=0. Four beats -> 0xFFFFFFFF, sat=1 (exact 2^32 overflows). Add a 5th beat [0] with last -> still 0xFFFFFFFF, sat=1, count=5.
- Backpressure: [5], last, then out_ready=0 for 5 cycles with in_valid=1, in_data=7 -> out_data=25 stable, in_ready=0, no accumulation. Raise out_ready, then send [1,1,1] -> 3, count=3.
- Gaps: beats [2], two idle cycles, [2] with last -> out_data=8, count=2.
- Reset: accept [10,10], assert reset asynchronously for 2 cycles, release, then send [1] with last -> out_data=1, count=1, sat=0. Check out_valid=0 during reset.

Source files
------------

// File: rtl/sumsq_accum.sv
// Streaming sum-of-squares accumulator feeding the square-root unit.
// Squares signed elements, accumulates with saturation, and holds the result under valid/ready.
module sumsq_accum #(
    parameter int unsigned dataLen = 16,
    parameter int unsigned outLen  = 32,
    parameter int unsigned cntLen  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [dataLen-1:0] in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [outLen-1:0]  out_data,
    output logic                      out_sat,
    output logic        [cntLen-1:0]  out_count
);

    localparam int unsigned sqLen = 2 * dataLen;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [outLen-1:0]  acc_q, acc_d;
    logic [cntLen-1:0]  cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [outLen-1:0]  odata_q, odata_d;
    logic               osat_q, osat_d;
    logic [cntLen-1:0]  ocount_q, ocount_d;

    logic signed [sqLen-1:0] din_ext;
    logic signed [sqLen-1:0] sq_s;
    logic        [sqLen-1:0] sq;
    logic        [outLen:0]  sum;
    logic [outLen-1:0]       acc_new;
    logic                    sat_new;
    logic [cntLen-1:0]       cnt_new;
    logic                    accept;

    // Sign-extend before multiplying so the full-width product is exact.
    assign din_ext = sqLen'(in_data);
    assign sq_s    = din_ext * din_ext;
    assign sq      = $unsigned(sq_s);
    assign sum     = {1'b0, acc_q} + {{(outLen + 1 - sqLen){1'b0}}, sq};

    assign sat_new = sat_q | sum[outLen];
    assign acc_new = sat_new ? {outLen{1'b1}} : sum[outLen-1:0];
    assign cnt_new = (&cnt_q) ? cnt_q : cnt_q + {{(cntLen-1){1'b0}}, 1'b1};

    assign in_ready  = (state_q != HOLD) && !reset;
    assign accept    = in_valid && (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign out_data  = odata_q;
    assign out_sat   = osat_q;
    assign out_count = ocount_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        odata_d  = odata_q;
        osat_d   = osat_q;
        ocount_d = ocount_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = acc_new;
                    cnt_d = cnt_new;
                    sat_d = sat_new;
                    if (in_last) begin
                        state_d  = HOLD;
                        odata_d  = acc_new;
                        osat_d   = sat_new;
                        ocount_d = cnt_new;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            odata_q  <= '0;
            osat_q   <= 1'b0;
            ocount_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            odata_q  <= odata_d;
            osat_q   <= osat_d;
            ocount_q <= ocount_d;
        end
    end

endmodule

// File: tb/tb_sumsq_accum.sv
// Directed bench for sumsq_accum: hand-computed sums, saturation, backpressure, gaps and reset.
module tb_sumsq_accum;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic               out_sat;
    logic [15:0]        out_count;

    int vecs = 0;
    int errs = 0;

    sumsq_accum #(.dataLen(16), .outLen(32), .cntLen(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    // Present one beat at the falling edge; it transfers on the following rising edge.
    task automatic beat(input logic [15:0] d, input logic l);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        vecs++; if (out_data !== 32'h0) begin errs++; $display("FAIL rst_data: got %h want 0", out_data); end
        vecs++; if (out_count !== 16'h0) begin errs++; $display("FAIL rst_count: got %h want 0", out_count); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL rst_sat: got %b want 0", out_sat); end
        reset = 1'b0;
        #1;
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        beat(16'd3, 1'b0);
        beat(16'd4, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        vecs++; if (out_data !== 32'd25) begin errs++; $display("FAIL basic_data: got %0d want 25", out_data); end
        vecs++; if (out_count !== 16'd2) begin errs++; $display("FAIL basic_count: got %0d want 2", out_count); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL basic_sat: got %b want 0", out_sat); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL basic_hold_ready: got %b want 0", in_ready); end
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL basic_valid_drop: got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL basic_ready_back: got %b want 1", in_ready); end
    endtask

    task automatic test_single;
        beat(16'h8000, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %b want 1", out_valid); end
        vecs++; if (out_data !== 32'h4000_0000) begin errs++; $display("FAIL single_data: got %h want 40000000", out_data); end
        vecs++; if (out_count !== 16'd1) begin errs++; $display("FAIL single_count: got %0d want 1", out_count); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL single_sat: got %b want 0", out_sat); end
        @(negedge clk);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 3; i++) beat(16'h8000, (i == 2));
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'hC000_0000) begin errs++; $display("FAIL sat3_data: got %h want c0000000", out_data); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL sat3_sat: got %b want 0", out_sat); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(16'h8000, (i == 3));
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL sat4_data: got %h want ffffffff", out_data); end
        vecs++; if (out_sat !== 1'b1) begin errs++; $display("FAIL sat4_sat: got %b want 1", out_sat); end
        vecs++; if (out_count !== 16'd4) begin errs++; $display("FAIL sat4_count: got %0d want 4", out_count); end
        @(negedge clk);
        for (int i = 0; i < 4; i++) beat(16'h8000, 1'b0);
        beat(16'd0, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'hFFFF_FFFF) begin errs++; $display("FAIL sat5_data: got %h want ffffffff", out_data); end
        vecs++; if (out_sat !== 1'b1) begin errs++; $display("FAIL sat5_sat: got %b want 1", out_sat); end
        vecs++; if (out_count !== 16'd5) begin errs++; $display("FAIL sat5_count: got %0d want 5", out_count); end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        beat(16'd5, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'd7; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            vecs++; if (out_data !== 32'd25) begin errs++; $display("FAIL bp_data[%0d]: got %0d want 25", i, out_data); end
            vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
            @(negedge clk);
        end
        // Handshake cycle with in_valid still high: the element must not be taken.
        out_ready = 1'b1;
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_hs_ready: got %b want 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp_valid_drop: got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) beat(16'd1, (i == 2));
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'd3) begin errs++; $display("FAIL bp_next_data: got %0d want 3", out_data); end
        vecs++; if (out_count !== 16'd3) begin errs++; $display("FAIL bp_next_count: got %0d want 3", out_count); end
        @(negedge clk);
    endtask

    task automatic test_gaps;
        beat(16'd2, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        beat(16'd2, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'd8) begin errs++; $display("FAIL gaps_data: got %0d want 8", out_data); end
        vecs++; if (out_count !== 16'd2) begin errs++; $display("FAIL gaps_count: got %0d want 2", out_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        beat(16'd10, 1'b0);
        beat(16'd10, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
        @(negedge clk);
        @(negedge clk);
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid_held: got %b want 0", out_valid); end
        reset = 1'b0;
        beat(16'd1, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_data !== 32'd1) begin errs++; $display("FAIL rmid_data: got %0d want 1", out_data); end
        vecs++; if (out_count !== 16'd1) begin errs++; $display("FAIL rmid_count: got %0d want 1", out_count); end
        vecs++; if (out_sat !== 1'b0) begin errs++; $display("FAIL rmid_sat: got %b want 0", out_sat); end
        @(negedge clk);
        // Reset while holding a result drops out_valid immediately.
        out_ready = 1'b0;
        beat(16'd9, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rhold_valid: got %b want 1", out_valid); end
        #2 reset = 1'b1;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rhold_drop: got %b want 0", out_valid); end
        @(negedge clk);
        reset = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_single;
        test_saturation;
        test_backpressure;
        test_gaps;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
